// File: rtl/bitsim_pkg.sv
// Shared constants and state encoding for the bit-serial lane select/scatter blocks.
package bitsim_pkg;
   localparam int NUM_LANE  = 16;
   localparam int SEL_WIDTH = 5;
   localparam logic [SEL_WIDTH-1:0] SEL_ZERO = 5'd16;

   typedef enum logic {S_FILL, S_HOLD} scatter_state_e;
endpackage

// File: rtl/scatter_lane_reg.sv
// One lane word register with its written-this-frame mask bit.
module scatter_lane_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  m
);
   // clr and we never coincide: clr only fires in HOLD, we only in FILL
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
         m <= 1'b0;
      end else if (clr) begin
         q <= '0;
         m <= 1'b0;
      end else if (we) begin
         q <= d;
         m <= 1'b1;
      end
   end
endmodule

// File: rtl/scatter_1to17_clk.sv
// Registered 1-to-17 lane scatter: builds a 16-lane frame from (word, select) pairs.
module scatter_1to17_clk
   import bitsim_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic [SEL_WIDTH-1:0]                in_sel,
   input  logic                                in_last,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_LANE-1:0][DATA_WIDTH-1:0] out_vec,
   output logic [NUM_LANE-1:0]                 out_mask,
   output logic                                err
);
   scatter_state_e state_q, state_d;

   logic accept, sel_lane, sel_bad, dup, clr;

   assign accept   = in_valid && in_ready;
   assign sel_lane = in_sel < SEL_ZERO;
   assign sel_bad  = in_sel > SEL_ZERO;
   assign dup      = sel_lane && out_mask[in_sel[3:0]];
   assign clr      = (state_q == S_HOLD) && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (accept && in_last) state_d = S_HOLD;
         S_HOLD:  if (out_ready)         state_d = S_FILL;
         default:                        state_d = S_FILL;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_FILL);
      out_valid = (state_q == S_HOLD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        err <= 1'b0;
      else if (accept && (sel_bad || dup)) err <= 1'b1;
   end

   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      scatter_lane_reg #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clk   (clk),
         .reset (reset),
         .we    (accept && sel_lane && (in_sel == SEL_WIDTH'(i))),
         .clr   (clr),
         .d     (in_data),
         .q     (out_vec[i]),
         .m     (out_mask[i])
      );
   end
endmodule

// File: doc/scatter_1to17_clk.md
# scatter_1to17_clk

Registered 1-to-17 lane scatter: accepts a stream of (word, select) pairs and deposits each word into one of 16 lane registers, or discards it when select 16 picks the implicit zero lane. The assembled 16-lane vector is presented as one frame with a valid/ready handshake. It is the write-side counterpart of the registered 17-to-1 lane select. It sits between the bit-serial operand fetch and the 16-lane PE array, building the lane vector that the select stage later reads.

## Interface
- DATA_WIDTH, 8, width of one lane word
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  DATA_WIDTH  word to scatter
- in_sel  in  5  destination lane: 0..15 is a lane, 16 is the zero lane (discard), 17..31 are illegal
- in_last  in  1  final word of the current frame
- out_valid  out  1  frame vector valid
- out_ready  in  1  consumer accepts frame
- out_vec  out  DATA_WIDTH x [15:0]  assembled lane vector
- out_mask  out  16  bit i = lane i written in this frame
- err  out  1  sticky: illegal select or duplicate lane write seen since reset

## Operation
- Two-state FSM:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid && in_ready.
- Accept in FILL, in_sel 0..15: lane[in_sel] <= in_data; mask[in_sel] <= 1.
- Accept in FILL, in_sel 16: no lane or mask change.
- Accept in FILL, in_sel 17..31: treated as 16 (discard); err <= 1.
- Accept to a lane whose mask bit is already 1: last write wins; err <= 1.
- Accept with in_last=1: word is written as above, then FILL -> HOLD.
- in_last on a discarded or illegal word still ends the frame.
- An empty frame (in_last on the first word, sel 16) emits an all-zero vector with mask 0.
- HOLD with out_ready=1: HOLD -> FILL; all lanes cleared to 0; mask cleared to 0.
- HOLD with out_ready=0: out_vec and out_mask are held stable.
- Lanes not written in a frame read as 0.
- err is cleared only by reset.
- in_valid while in_ready=0 is ignored; the upstream holds the word until in_ready=1.

## Timing
- Reset (reset=0, asynchronous): state=FILL, all lanes=0, mask=0, err=0, in_ready=1, out_valid=0.
- Reset mid-frame or mid-HOLD discards the partial or pending frame.
- Deassertion of reset is synchronised externally; the first accept can occur on the first rising edge with reset=1.
- Write latency is 1 cycle: a word accepted at edge t is visible in out_vec after edge t.
- If that word carries in_last, out_valid=1 in the cycle after edge t.
- Frame turnaround: the handshake edge returns to FILL, and in_ready=1 in the next cycle. Minimum frame period is N+1 cycles for N words.
- There is no combinational path from in_valid or out_ready to any output except through the state register.
- in_ready and out_valid are decoded from the state register only.

## Structure
- Shared package bitsim_pkg holds:
  - NUM_LANE=16, SEL_WIDTH=5, SEL_ZERO=5'd16
  - scatter state enum {S_FILL, S_HOLD}
- Sub-module scatter_lane_reg: one DATA_WIDTH register plus its mask bit.
  - Inputs: write enable, clear, async active-low reset.
  - Instantiated 16 times by a generate loop.
- Top level holds the FSM, select decode, err flag and handshake.

## Test plan
- Reset then out_ready=1: send sel 0..15 with data 8'h10+i, in_last on sel 15 -> one cycle later out_valid=1, out_vec[i]=8'h10+i, out_mask=16'hFFFF, err=0.
- Send sel 3 = 8'hAA, sel 16 = 8'hFF, then sel 7 = 8'h55 with in_last -> out_vec[3]=8'hAA, out_vec[7]=8'h55, other lanes 0, out_mask=16'h0088, err=0.
- Complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_vec stable. Raise out_ready -> next cycle in_ready=1, out_mask=0.
- sel 20 with data 8'h01 and in_last -> all-zero vector, out_mask=0, err=1. err stays 1 through the next clean frame.
- sel 2 = 8'h11, then sel 2 = 8'h22 with in_last -> out_vec[2]=8'h22, out_mask=16'h0004, err=1.
- Assert reset=0 mid-HOLD -> outputs go to reset values immediately, without waiting for a clock edge. The next frame assembles correctly.
